// File: rtl/control_pkg.sv
// Shared constants for the multicycle MIPS-subset control unit: opcodes,
// functs, FSM state encoding, mux encodings and ALU control codes.
package control_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpJ     = 6'h02;

  // R-type functs (IR[5:0])
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  // ALU control codes
  localparam logic [2:0] AluCtlAdd = 3'b010;
  localparam logic [2:0] AluCtlSub = 3'b110;
  localparam logic [2:0] AluCtlAnd = 3'b000;
  localparam logic [2:0] AluCtlOr  = 3'b001;
  localparam logic [2:0] AluCtlSlt = 3'b111;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StExecR  = 4'd2,
    StWbR    = 4'd3,
    StExecI  = 4'd4,
    StWbI    = 4'd5,
    StAddr   = 4'd6,
    StMemRd  = 4'd7,
    StWbMem  = 4'd8,
    StMemWr  = 4'd9,
    StBranch = 4'd10,
    StJump   = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    SrcBReg   = 2'd0,
    SrcBFour  = 2'd1,
    SrcBImm   = 2'd2,
    SrcBImmSh = 2'd3
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PcSrcAlu    = 2'd0,
    PcSrcAluOut = 2'd1,
    PcSrcJump   = 2'd2
  } pc_source_e;

  // ALU operation class requested by the FSM
  typedef enum logic [1:0] {
    AluOpAdd   = 2'd0,
    AluOpSub   = 2'd1,
    AluOpFunct = 2'd2
  } alu_op_e;

endpackage

// File: rtl/control_alu.sv
// ALU control decoder: maps the FSM's operation class and the funct field to
// the 3-bit ALU control code, and flags functs outside the supported set.
module control_alu
  import control_pkg::*;
(
  input  alu_op_e    alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o,
  output logic       funct_illegal_o
);

  // Decode operation class; funct legality is reported independently of class
  always_comb begin
    alu_control_o   = AluCtlAdd;
    funct_illegal_o = 1'b0;
    unique case (funct_i)
      FnAdd, FnSub, FnAnd, FnOr, FnSlt: funct_illegal_o = 1'b0;
      default:                          funct_illegal_o = 1'b1;
    endcase
    unique case (alu_op_i)
      AluOpAdd: alu_control_o = AluCtlAdd;
      AluOpSub: alu_control_o = AluCtlSub;
      AluOpFunct: begin
        unique case (funct_i)
          FnAdd:   alu_control_o = AluCtlAdd;
          FnSub:   alu_control_o = AluCtlSub;
          FnAnd:   alu_control_o = AluCtlAnd;
          FnOr:    alu_control_o = AluCtlOr;
          FnSlt:   alu_control_o = AluCtlSlt;
          default: alu_control_o = AluCtlAdd;
        endcase
      end
      default: alu_control_o = AluCtlAdd;
    endcase
  end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle control unit: holds the instruction register, sequences
// fetch/decode/execute/memory/writeback and drives the datapath controls.
module control_multiciclo
  import control_pkg::*;
#(
  parameter int unsigned ANCHO_DIR = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          instr,
  input  logic                 memReady,
  input  logic                 zero,
  output logic [ANCHO_DIR-1:0] A1,
  output logic [ANCHO_DIR-1:0] A2,
  output logic [ANCHO_DIR-1:0] A3,
  output logic                 writeRegister,
  output logic                 memToReg,
  output logic                 irWrite,
  output logic                 pcWrite,
  output logic                 pcWriteCond,
  output logic                 memRead,
  output logic                 memWrite,
  output logic                 iord,
  output logic                 aluSrcA,
  output logic [1:0]           aluSrcB,
  output logic [1:0]           pcSource,
  output logic [2:0]           aluControl,
  output logic                 illegalOp,
  output logic [3:0]           estado
);

  state_e      state_q, state_d;
  logic [31:0] ir_q;
  logic        illegal_q;
  logic        illegal_set;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        funct_illegal;
  logic        dest_nz;
  alu_op_e     alu_op;
  alu_src_b_e  src_b;
  pc_source_e  pc_src;

  assign opcode = ir_q[31:26];
  assign funct  = ir_q[5:0];

  assign A1 = ir_q[21 +: ANCHO_DIR];
  assign A2 = ir_q[16 +: ANCHO_DIR];
  assign A3 = (opcode == OpRtype) ? ir_q[11 +: ANCHO_DIR] : ir_q[16 +: ANCHO_DIR];

  // Writes to register 0 are dropped at the strobe; A3 is still driven
  assign dest_nz = (A3 != '0);

  assign illegalOp = illegal_q;
  assign estado    = state_q;
  assign aluSrcB   = src_b;
  assign pcSource  = pc_src;

  // zero is qualified with pcWriteCond in the datapath; shamt is not decoded
  logic unused_bits;
  assign unused_bits = ^{zero, ir_q[10:6]};

  control_alu u_control_alu (
    .alu_op_i        (alu_op),
    .funct_i         (funct),
    .alu_control_o   (aluControl),
    .funct_illegal_o (funct_illegal)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction register and sticky illegal-operation flag
  always_ff @(posedge clock) begin
    if (reset) begin
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (irWrite) begin
        ir_q <= instr;
      end
      if (illegal_set) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Next-state logic and illegal detection
  always_comb begin
    state_d     = state_q;
    illegal_set = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (memReady) state_d = StDecode;
      end
      StDecode: begin
        case (opcode)
          OpRtype:    state_d = StExecR;
          OpAddi:     state_d = StExecI;
          OpLw, OpSw: state_d = StAddr;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          default: begin
            state_d     = StFetch;
            illegal_set = 1'b1;
          end
        endcase
      end
      StExecR: begin
        state_d     = StWbR;
        illegal_set = funct_illegal;
      end
      StExecI: state_d = StWbI;
      StAddr:  state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd: begin
        if (memReady) state_d = StWbMem;
      end
      StMemWr: begin
        if (memReady) state_d = StFetch;
      end
      StWbR, StWbI, StWbMem, StBranch, StJump: state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  // Moore output decode; only FETCH's irWrite/pcWrite look at memReady
  always_comb begin
    writeRegister = 1'b0;
    memToReg      = 1'b0;
    irWrite       = 1'b0;
    pcWrite       = 1'b0;
    pcWriteCond   = 1'b0;
    memRead       = 1'b0;
    memWrite      = 1'b0;
    iord          = 1'b0;
    aluSrcA       = 1'b0;
    src_b         = SrcBReg;
    pc_src        = PcSrcAlu;
    alu_op        = AluOpAdd;
    unique case (state_q)
      StFetch: begin
        memRead = 1'b1;
        src_b   = SrcBFour;
        irWrite = memReady;
        pcWrite = memReady;
      end
      StDecode: src_b = SrcBImmSh;
      StExecR: begin
        aluSrcA = 1'b1;
        alu_op  = AluOpFunct;
      end
      StWbR: writeRegister = dest_nz & ~funct_illegal;
      StExecI, StAddr: begin
        aluSrcA = 1'b1;
        src_b   = SrcBImm;
      end
      StWbI: writeRegister = dest_nz;
      StMemRd: begin
        memRead = 1'b1;
        iord    = 1'b1;
      end
      StWbMem: begin
        writeRegister = dest_nz;
        memToReg      = 1'b1;
      end
      StMemWr: begin
        memWrite = 1'b1;
        iord     = 1'b1;
      end
      StBranch: begin
        aluSrcA     = 1'b1;
        alu_op      = AluOpSub;
        pcWriteCond = 1'b1;
        pc_src      = PcSrcAluOut;
      end
      StJump: begin
        pcWrite = 1'b1;
        pc_src  = PcSrcJump;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_multiciclo.sv
// Self-checking bench for control_multiciclo: directed scenarios plus a random
// instruction stream with random memory wait states, checked against a
// per-instruction reference model of cycle counts and strobe activity.
module tb_control_multiciclo;
  import control_pkg::*;

  logic        clock = 1'b0;
  logic        reset, memReady, zero;
  logic [31:0] instr;
  logic [4:0]  A1, A2, A3;
  logic        writeRegister, memToReg, irWrite, pcWrite, pcWriteCond;
  logic        memRead, memWrite, iord, aluSrcA, illegalOp;
  logic [1:0]  aluSrcB, pcSource;
  logic [2:0]  aluControl;
  logic [3:0]  estado;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  control_multiciclo #(.ANCHO_DIR(5)) dut (
    .clock         (clock),
    .reset         (reset),
    .instr         (instr),
    .memReady      (memReady),
    .zero          (zero),
    .A1            (A1),
    .A2            (A2),
    .A3            (A3),
    .writeRegister (writeRegister),
    .memToReg      (memToReg),
    .irWrite       (irWrite),
    .pcWrite       (pcWrite),
    .pcWriteCond   (pcWriteCond),
    .memRead       (memRead),
    .memWrite      (memWrite),
    .iord          (iord),
    .aluSrcA       (aluSrcA),
    .aluSrcB       (aluSrcB),
    .pcSource      (pcSource),
    .aluControl    (aluControl),
    .illegalOp     (illegalOp),
    .estado        (estado)
  );

  // Observations of the last instruction run through run_instr
  int         obs_cycles, obs_wr_cnt, obs_wr_cycle, obs_pcw_cnt, obs_pcwc_cnt;
  int         obs_pcwc_cycle, obs_memwr_cnt;
  logic [4:0] obs_wr_a3, obs_a1, obs_a2;
  logic [1:0] obs_pcwc_src, obs_jump_src;
  logic       obs_m2r, obs_ill, obs_timeout;

  // ---------------- reference model ----------------
  function automatic bit ref_funct_ok(input logic [31:0] ins);
    logic [5:0] f;
    f = ins[5:0];
    return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) || (f == 6'h25) || (f == 6'h2A);
  endfunction

  function automatic int ref_cycles(input logic [31:0] ins, input int fw, input int mw);
    logic [5:0] op;
    op = ins[31:26];
    case (op)
      6'h00, 6'h08: return 4 + fw;
      6'h23:        return 5 + fw + mw;
      6'h2B:        return 4 + fw + mw;
      6'h04, 6'h02: return 3 + fw;
      default:      return 2 + fw;
    endcase
  endfunction

  function automatic logic [4:0] ref_dest(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    return (op == 6'h00) ? ins[15:11] : ins[20:16];
  endfunction

  function automatic bit ref_writes(input logic [31:0] ins);
    logic [5:0] op;
    bit         wr;
    op = ins[31:26];
    wr = ((op == 6'h00) && ref_funct_ok(ins)) || (op == 6'h08) || (op == 6'h23);
    return wr && (ref_dest(ins) != 5'd0);
  endfunction

  function automatic bit ref_illegal(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    if (op == 6'h00) return !ref_funct_ok(ins);
    return !((op == 6'h23) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h08) || (op == 6'h02));
  endfunction

  // ---------------- stimulus ----------------
  // Called at a negedge with reset released afterwards; DUT sits in FETCH.
  task automatic do_reset();
    reset    = 1'b1;
    memReady = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Runs one instruction from its FETCH to the next FETCH. fw/mw are the wait
  // cycles for the instruction and data access; zsel 0/1 fixes zero, 2 = random.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input int zsel);
    int fc, mc, cyc;
    bit seen_ir, prev_ir;
    fc = fw; mc = mw; cyc = 0; seen_ir = 0; prev_ir = 0;
    instr = ins;
    obs_wr_cnt = 0; obs_wr_cycle = 0; obs_pcw_cnt = 0; obs_pcwc_cnt = 0;
    obs_pcwc_cycle = 0; obs_memwr_cnt = 0; obs_wr_a3 = '0; obs_a1 = '0; obs_a2 = '0;
    obs_pcwc_src = '0; obs_jump_src = '0; obs_m2r = 1'b0; obs_timeout = 1'b0;
    forever begin
      cyc++;
      zero = (zsel == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel);
      if (memRead && !iord) begin
        memReady = (fc == 0);
        if (fc > 0) fc--;
      end else if ((memRead || memWrite) && iord) begin
        memReady = (mc == 0);
        if (mc > 0) mc--;
      end else begin
        memReady = 1'($urandom_range(0, 1));
      end
      #1;
      if (prev_ir) begin
        obs_a1 = A1;
        obs_a2 = A2;
      end
      prev_ir = irWrite;
      if (irWrite) seen_ir = 1;
      if (writeRegister) begin
        obs_wr_cnt++;
        obs_wr_cycle = cyc;
        obs_wr_a3    = A3;
        obs_m2r      = memToReg;
      end
      if (pcWrite) begin
        obs_pcw_cnt++;
        if (!irWrite) obs_jump_src = pcSource;
      end
      if (pcWriteCond) begin
        obs_pcwc_cnt++;
        obs_pcwc_cycle = cyc;
        obs_pcwc_src   = pcSource;
      end
      if (memWrite) obs_memwr_cnt++;
      @(posedge clock);
      @(negedge clock);
      if (seen_ir && !prev_ir && memRead && !iord) break;
      if (cyc > 40) begin
        obs_timeout = 1'b1;
        break;
      end
    end
    obs_cycles = cyc;
    obs_ill    = illegalOp;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    instr = 32'h0; zero = 1'b0;
    do_reset();
    #1;
    checks++; if (estado !== StFetch) begin errors++; $display("FAIL reset_estado got=%0d want=%0d", estado, StFetch); end
    checks++; if (memRead !== 1'b1) begin errors++; $display("FAIL reset_memRead got=%b want=1", memRead); end
    checks++; if ({irWrite, pcWrite, pcWriteCond, memWrite, writeRegister, iord} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes got=%b want=000000",
                         {irWrite, pcWrite, pcWriteCond, memWrite, writeRegister, iord});
    end
    checks++; if (illegalOp !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b want=0", illegalOp); end
    checks++; if ({A1, A2, A3} !== 15'b0) begin errors++; $display("FAIL reset_addr got=%h want=0", {A1, A2, A3}); end
  endtask

  task automatic test_add();
    run_instr(32'h012A4020, 0, 0, 2);
    checks++; if (obs_cycles !== 4) begin errors++; $display("FAIL add_cycles got=%0d want=4", obs_cycles); end
    checks++; if (obs_a1 !== 5'd9 || obs_a2 !== 5'd10) begin
      errors++; $display("FAIL add_A1A2 got=%0d,%0d want=9,10", obs_a1, obs_a2);
    end
    checks++; if (obs_wr_cnt !== 1 || obs_wr_cycle !== 4) begin
      errors++; $display("FAIL add_wr got=cnt%0d@%0d want=cnt1@4", obs_wr_cnt, obs_wr_cycle);
    end
    checks++; if (obs_wr_a3 !== 5'd8 || obs_m2r !== 1'b0) begin
      errors++; $display("FAIL add_A3 got=%0d m2r=%b want=8 m2r=0", obs_wr_a3, obs_m2r);
    end
  endtask

  task automatic test_lw_wait();
    run_instr(32'h8C850008, 0, 2, 2);
    checks++; if (obs_cycles !== 7) begin errors++; $display("FAIL lw_cycles got=%0d want=7", obs_cycles); end
    checks++; if (obs_wr_cnt !== 1 || obs_wr_a3 !== 5'd5 || obs_m2r !== 1'b1) begin
      errors++; $display("FAIL lw_wb got=cnt%0d A3=%0d m2r=%b want=cnt1 A3=5 m2r=1",
                         obs_wr_cnt, obs_wr_a3, obs_m2r);
    end
  endtask

  task automatic test_beq();
    run_instr(32'h10220003, 0, 0, 1);
    checks++; if (obs_cycles !== 3) begin errors++; $display("FAIL beq_cycles got=%0d want=3", obs_cycles); end
    checks++; if (obs_pcwc_cnt !== 1 || obs_pcwc_cycle !== 3 || obs_pcwc_src !== 2'd1) begin
      errors++; $display("FAIL beq_pcwc got=cnt%0d@%0d src=%0d want=cnt1@3 src=1",
                         obs_pcwc_cnt, obs_pcwc_cycle, obs_pcwc_src);
    end
    checks++; if (estado !== StFetch) begin errors++; $display("FAIL beq_back got=%0d want=%0d", estado, StFetch); end
  endtask

  task automatic test_addi_zero();
    run_instr(32'h20600007, 1, 0, 2);
    checks++; if (obs_wr_cnt !== 0) begin errors++; $display("FAIL addi0_wr got=%0d want=0", obs_wr_cnt); end
    checks++; if (obs_cycles !== 5) begin errors++; $display("FAIL addi0_cycles got=%0d want=5", obs_cycles); end
  endtask

  task automatic test_illegal();
    run_instr(32'hFC000000, 0, 0, 2);
    checks++; if (obs_ill !== 1'b1) begin errors++; $display("FAIL illop_set got=%b want=1", obs_ill); end
    checks++; if (obs_cycles !== 2 || estado !== StFetch) begin
      errors++; $display("FAIL illop_fetch got=cyc%0d st%0d want=cyc2 st%0d", obs_cycles, estado, StFetch);
    end
    run_instr(32'h012A4020, 0, 0, 2);
    checks++; if (illegalOp !== 1'b1) begin errors++; $display("FAIL illop_sticky got=%b want=1", illegalOp); end
    do_reset();
    #1;
    checks++; if (illegalOp !== 1'b0) begin errors++; $display("FAIL illop_clear got=%b want=0", illegalOp); end
  endtask

  task automatic test_reset_mem_wr();
    instr = 32'hAC850004;
    memReady = 1'b1;
    repeat (3) begin @(posedge clock); @(negedge clock); end
    memReady = 1'b0;
    @(posedge clock); @(negedge clock);
    #1;
    checks++; if (memWrite !== 1'b1 || iord !== 1'b1) begin
      errors++; $display("FAIL memwr_hold got=mw%b iord%b want=mw1 iord1", memWrite, iord);
    end
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (estado !== StFetch || memWrite !== 1'b0) begin
      errors++; $display("FAIL memwr_abort got=st%0d mw%b want=st%0d mw0", estado, memWrite, StFetch);
    end
    checks++; if ({writeRegister, pcWriteCond, pcWrite, irWrite} !== 4'b0 || memRead !== 1'b1) begin
      errors++; $display("FAIL memwr_abort_strb got=%b rd%b want=0000 rd1",
                         {writeRegister, pcWriteCond, pcWrite, irWrite}, memRead);
    end
  endtask

  task automatic test_random();
    logic [5:0]  ops [8];
    logic [5:0]  fns [5];
    logic [31:0] ins, r;
    int          fw, mw, sel;
    bit          exp_ill;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h00, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    do_reset();
    exp_ill = 0;
    for (int n = 0; n < 60; n++) begin
      r   = $urandom();
      sel = $urandom_range(0, 7);
      ins = {ops[sel], r[25:0]};
      if (sel == 0) ins[5:0] = fns[$urandom_range(0, 4)];
      if (sel == 7 && r[0]) ins[31:26] = 6'h01;
      if (n % 10 == 3) ins[15:11] = 5'd0;
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 3);
      exp_ill = exp_ill | ref_illegal(ins);
      run_instr(ins, fw, mw, 2);
      checks++; if (obs_timeout || obs_cycles !== ref_cycles(ins, fw, mw)) begin
        errors++; $display("FAIL rnd%0d_cycles ins=%h got=%0d want=%0d", n, ins, obs_cycles,
                           ref_cycles(ins, fw, mw));
      end
      checks++; if (obs_wr_cnt !== int'(ref_writes(ins))) begin
        errors++; $display("FAIL rnd%0d_wrcnt ins=%h got=%0d want=%0d", n, ins, obs_wr_cnt,
                           ref_writes(ins));
      end
      if (ref_writes(ins)) begin
        checks++; if (obs_wr_a3 !== ref_dest(ins) || obs_m2r !== (ins[31:26] == 6'h23) ||
                      obs_wr_cycle !== obs_cycles) begin
          errors++; $display("FAIL rnd%0d_wb ins=%h got=A3 %0d m2r %b @%0d want=A3 %0d @%0d",
                             n, ins, obs_wr_a3, obs_m2r, obs_wr_cycle, ref_dest(ins), obs_cycles);
        end
      end
      checks++; if (obs_a1 !== ins[25:21] || obs_a2 !== ins[20:16]) begin
        errors++; $display("FAIL rnd%0d_A1A2 ins=%h got=%0d,%0d want=%0d,%0d", n, ins, obs_a1,
                           obs_a2, ins[25:21], ins[20:16]);
      end
      checks++; if (obs_pcw_cnt !== ((ins[31:26] == 6'h02) ? 2 : 1) ||
                    obs_pcwc_cnt !== ((ins[31:26] == 6'h04) ? 1 : 0)) begin
        errors++; $display("FAIL rnd%0d_pc ins=%h got=pcw%0d pcwc%0d", n, ins, obs_pcw_cnt,
                           obs_pcwc_cnt);
      end
      if (ins[31:26] == 6'h02) begin
        checks++; if (obs_jump_src !== 2'd2) begin
          errors++; $display("FAIL rnd%0d_jsrc got=%0d want=2", n, obs_jump_src);
        end
      end
      checks++; if (obs_memwr_cnt !== ((ins[31:26] == 6'h2B) ? mw + 1 : 0)) begin
        errors++; $display("FAIL rnd%0d_memwr ins=%h got=%0d mw=%0d", n, ins, obs_memwr_cnt, mw);
      end
      checks++; if (obs_ill !== exp_ill) begin
        errors++; $display("FAIL rnd%0d_ill ins=%h got=%b want=%b", n, ins, obs_ill, exp_ill);
      end
    end
  endtask

  initial begin
    reset = 1'b1; memReady = 1'b0; zero = 1'b0; instr = 32'h0;
    @(negedge clock);
    test_reset();
    test_add();
    test_lw_wait();
    test_beq();
    test_addi_zero();
    test_illegal();
    test_reset_mem_wr();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
